// File: rtl/iterative_divider_16bit.sv
// Signed 16-bit restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               begin a division (accepted in IDLE or DONE only)
//   dividend, divisor   two's-complement operands, sampled on accept
//   busy                high while iterating (state DIV)
//   done                one-cycle pulse, results valid (state DONE)
//   quotient            signed quotient, truncated toward zero
//   remainder           signed remainder, sign follows dividend
//   Error               divide-by-zero or overflow on the last result
module iterative_divider_16bit (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [15:0]   dividend,
  input  logic [15:0]   divisor,
  output logic          busy,
  output logic          done,
  output logic [15:0]   quotient,
  output logic [15:0]   remainder,
  output logic          Error
);

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    rem_q;
  logic [W-1:0]    quo_q;
  logic [W-1:0]    dvs_q;
  logic            qneg_q;
  logic            rneg_q;
  logic            pend_q;   // special-case result waiting one cycle before DONE

  logic            accept_c;
  logic            div_zero_c;
  logic            ovf_c;
  logic            special_c;
  logic            last_iter_c;
  logic [W:0]      dvd_ext_c;
  logic [W:0]      dvs_ext_c;
  logic [W-1:0]    dvd_abs_c;
  logic [W-1:0]    dvs_abs_c;
  logic [W:0]      trial_c;
  logic            ge_c;
  logic [W-1:0]    rem_nx_c;
  logic [W-1:0]    quo_nx_c;

  // Operand classification and accept decode
  always_comb begin
    accept_c    = start && !pend_q && ((state == IDLE) || (state == DONE));
    div_zero_c  = (divisor == 16'h0000);
    ovf_c       = (dividend == 16'h8000) && (divisor == 16'hFFFF);
    special_c   = div_zero_c || ovf_c;
    last_iter_c = (state == DIV) && (cnt_q == CW'(W - 1));
  end

  // Magnitudes via 17-bit negate so |0x8000| = 32768 survives in 16 unsigned bits
  always_comb begin
    dvd_ext_c = {dividend[W-1], dividend};
    dvs_ext_c = {divisor[W-1], divisor};
    dvd_abs_c = dividend[W-1] ? W'((~dvd_ext_c) + 17'd1) : dividend;
    dvs_abs_c = divisor[W-1]  ? W'((~dvs_ext_c) + 17'd1) : divisor;
  end

  // One restoring step: shift dividend MSB into partial remainder, trial subtract
  always_comb begin
    trial_c  = {rem_q, quo_q[W-1]};
    ge_c     = (trial_c >= {1'b0, dvs_q});
    rem_nx_c = ge_c ? W'(trial_c - {1'b0, dvs_q}) : trial_c[W-1:0];
    quo_nx_c = {quo_q[W-2:0], ge_c};
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (pend_q)                      state_nx = DONE;
        else if (accept_c && !special_c) state_nx = DIV;
      end
      DIV: begin
        if (last_iter_c) state_nx = DONE;
      end
      DONE: begin
        if (accept_c && !special_c) state_nx = DIV;
        else                        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register with registered status decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == DIV);
      done  <= (state_nx == DONE);
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      pend_q    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      Error     <= 1'b0;
    end else if (accept_c) begin
      cnt_q  <= '0;
      pend_q <= special_c;
      if (div_zero_c) begin
        quo_q <= dividend[W-1] ? 16'h8000 : 16'h7FFF;
        rem_q <= dividend;
      end else if (ovf_c) begin
        quo_q <= 16'h7FFF;
        rem_q <= 16'h0000;
      end else begin
        quo_q  <= dvd_abs_c;
        rem_q  <= '0;
        dvs_q  <= dvs_abs_c;
        qneg_q <= dividend[W-1] ^ divisor[W-1];
        rneg_q <= dividend[W-1];
      end
    end else if (pend_q) begin
      pend_q    <= 1'b0;
      quotient  <= quo_q;
      remainder <= rem_q;
      Error     <= 1'b1;
    end else if (state == DIV) begin
      rem_q <= rem_nx_c;
      quo_q <= quo_nx_c;
      cnt_q <= cnt_q + CW'(1);
      if (last_iter_c) begin
        quotient  <= qneg_q ? W'((~quo_nx_c) + 16'd1) : quo_nx_c;
        remainder <= rneg_q ? W'((~rem_nx_c) + 16'd1) : rem_nx_c;
        Error     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iterative_divider_16bit.sv
// Scoreboard bench for iterative_divider_16bit: driver pushes expected
// results, a negedge monitor pops and compares on each done pulse.
module tb_iterative_divider_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        Error;

  iterative_divider_16bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .Error     (Error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        err;
    int          due;
    int          bsy;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   bcnt = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every done pulse against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("quotient", int'(quotient), int'(e.q));
          chk("remainder", int'(remainder), int'(e.r));
          chk("error", int'(Error), int'(e.err));
          chk("done_cycle", cyc, e.due);
          chk("busy_cycles", bcnt, e.bsy);
        end
        bcnt = 0;
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        e = sb.pop_front();
        chk("done_timeout", cyc, e.due);
      end
    end
  end

  // Issue one operation and wait until its done cycle (next call may go back-to-back)
  task automatic run(input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] q, input logic [15:0] r, input logic err);
    exp_t e;
    int   lat;
    lat = err ? 1 : 16;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.q = q; e.r = r; e.err = err; e.due = cyc + 1 + lat; e.bsy = err ? 0 : 16;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (lat - 1) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    // Reset state
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_error", int'(Error), 0);
    #9 rst_n = 1'b1;

    // Basic, signed and boundary cases, back-to-back from DONE
    run(16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0);
    run(16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0);
    run(16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0);
    run(16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0);
    run(16'h8000, 16'h0002, 16'hC000, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    run(16'h0005, 16'h0000, 16'h7FFF, 16'h0005, 1'b1);
    run(16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b1);
    run(16'hFFFB, 16'h0000, 16'h8000, 16'hFFFB, 1'b1);
    run(16'h7FFF, 16'h0001, 16'h7FFF, 16'h0000, 1'b0);
    run(16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0);
    run(16'h0003, 16'h0007, 16'h0000, 16'h0003, 1'b0);
    run(16'h8000, 16'h8000, 16'h0001, 16'h0000, 1'b0);
    run(16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 1'b0);
    repeat (2) @(negedge clk);

    // Start during DIV is ignored; result arrives on schedule
    dividend = 16'h03E8; divisor = 16'h0003; start = 1'b1;
    e.q = 16'h014D; e.r = 16'h0001; e.err = 1'b0; e.due = cyc + 17; e.bsy = 16;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_quotient", int'(quotient), 16'h0000);
    chk("hold_remainder", int'(remainder), 16'h7FFF);
    dividend = 16'h0001; divisor = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-DIV
    dividend = 16'h0064; divisor = 16'h0007; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_quotient", int'(quotient), 0);
    chk("arst_remainder", int'(remainder), 0);
    chk("arst_error", int'(Error), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    run(16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0);

    repeat (20) @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pending_at_end", cyc, e.due);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
